// File: rtl/tour_cmd_seq.sv
// Tour command sequencer: replays one-hot knight moves from TourLogic as two single-axis
// cmd_proc commands each, and passes UART commands through while idle.
module tour_cmd_seq #(
    parameter int          NUM_MOVES = 24,
    parameter int          IDX_W     = 5,
    parameter logic [7:0]  HDG_N     = 8'h00,
    parameter logic [7:0]  HDG_S     = 8'h7F,
    parameter logic [7:0]  HDG_E     = 8'hBF,
    parameter logic [7:0]  HDG_W     = 8'h3F,
    parameter logic [7:0]  RESP_DONE = 8'hA5,
    parameter logic [7:0]  RESP_BUSY = 8'h5A
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_tour,
    input  logic             vert_first,
    input  logic             abort,
    input  logic [7:0]       move,
    output logic [IDX_W-1:0] mv_indx,
    input  logic [15:0]      cmd_UART,
    input  logic             cmd_rdy_UART,
    output logic [15:0]      cmd,
    output logic             cmd_rdy,
    input  logic             clr_cmd_rdy,
    input  logic             send_resp,
    output logic [7:0]       resp,
    output logic             tour_busy,
    output logic             tour_done,
    output logic             move_err
);

    generate
        if ((2 ** IDX_W) < NUM_MOVES) begin : g_idx_width_check
            $error("tour_cmd_seq: IDX_W too small for NUM_MOVES");
        end
    endgenerate

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, LEG1, WAIT1, LEG2, WAIT2} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  move_q;
    logic        order_q;
    logic        last_move;
    logic        move_ok;
    logic        abort_now;
    logic        vert_up;
    logic        horz_east;
    logic [3:0]  vert_cnt;
    logic [3:0]  horz_cnt;
    logic [15:0] vert_cmd;
    logic [15:0] horz_cmd;
    logic [15:0] leg1_cmd;
    logic [15:0] leg2_cmd;

    assign last_move = (mv_indx == LAST_IDX);
    assign move_ok   = (move != 8'd0) && ((move & (move - 8'd1)) == 8'd0);
    assign abort_now = abort && (state != IDLE);
    assign tour_busy = (state != IDLE);

    // Knight move table: direction and magnitude of each axis for every one-hot bit
    always_comb begin
        vert_up   = 1'b0;
        horz_east = 1'b0;
        vert_cnt  = 4'd0;
        horz_cnt  = 4'd0;
        case (move_q)
            8'h01: begin vert_up = 1'b1; vert_cnt = 4'd2; horz_east = 1'b0; horz_cnt = 4'd1; end
            8'h02: begin vert_up = 1'b1; vert_cnt = 4'd2; horz_east = 1'b1; horz_cnt = 4'd1; end
            8'h04: begin vert_up = 1'b1; vert_cnt = 4'd1; horz_east = 1'b0; horz_cnt = 4'd2; end
            8'h08: begin vert_up = 1'b0; vert_cnt = 4'd1; horz_east = 1'b0; horz_cnt = 4'd2; end
            8'h10: begin vert_up = 1'b0; vert_cnt = 4'd2; horz_east = 1'b0; horz_cnt = 4'd1; end
            8'h20: begin vert_up = 1'b0; vert_cnt = 4'd2; horz_east = 1'b1; horz_cnt = 4'd1; end
            8'h40: begin vert_up = 1'b0; vert_cnt = 4'd1; horz_east = 1'b1; horz_cnt = 4'd2; end
            8'h80: begin vert_up = 1'b1; vert_cnt = 4'd1; horz_east = 1'b1; horz_cnt = 4'd2; end
            default: ;
        endcase
    end

    assign vert_cmd = {4'b0010, (vert_up ? HDG_N : HDG_S), vert_cnt};
    assign horz_cmd = {4'b0011, (horz_east ? HDG_E : HDG_W), horz_cnt};
    assign leg1_cmd = order_q ? vert_cmd : horz_cmd;
    assign leg2_cmd = order_q ? horz_cmd : vert_cmd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd       = leg1_cmd;
        cmd_rdy   = 1'b0;
        resp      = RESP_BUSY;
        case (state)
            IDLE: begin
                cmd     = cmd_UART;
                cmd_rdy = cmd_rdy_UART;
                resp    = RESP_DONE;
                if (start_tour) state_nxt = LOAD;
            end
            LOAD: begin
                state_nxt = move_ok ? LEG1 : IDLE;
            end
            LEG1: begin
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy) state_nxt = WAIT1;
            end
            WAIT1: begin
                if (send_resp) state_nxt = LEG2;
            end
            LEG2: begin
                cmd     = leg2_cmd;
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy) state_nxt = WAIT2;
            end
            WAIT2: begin
                cmd = leg2_cmd;
                if (last_move) resp = RESP_DONE;
                if (send_resp) state_nxt = last_move ? IDLE : LOAD;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort_now) state_nxt = IDLE;
    end

    // Abort suppresses every datapath update, so mv_indx is frozen and no pulse fires
    always_ff @(posedge clk) begin
        if (rst) begin
            mv_indx   <= '0;
            move_q    <= 8'd0;
            order_q   <= 1'b0;
            tour_done <= 1'b0;
            move_err  <= 1'b0;
        end else begin
            tour_done <= 1'b0;
            move_err  <= 1'b0;
            if (!abort_now) begin
                case (state)
                    IDLE: begin
                        if (start_tour) begin
                            mv_indx <= '0;
                            order_q <= vert_first;
                        end
                    end
                    LOAD: begin
                        move_q <= move;
                        if (!move_ok) move_err <= 1'b1;
                    end
                    WAIT2: begin
                        if (send_resp) begin
                            if (last_move) tour_done <= 1'b1;
                            else           mv_indx   <= mv_indx + IDX_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Randomized scoreboard bench for tour_cmd_seq: expected legs come from a knight-move
// reference model and are checked by a monitor whenever cmd_proc accepts a command.
module tb_tour_cmd_seq;

    localparam int NUM_MOVES = 24;
    localparam int IDX_W     = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start_tour = 1'b0;
    logic             vert_first = 1'b0;
    logic             abort = 1'b0;
    logic [7:0]       move;
    logic [IDX_W-1:0] mv_indx;
    logic [15:0]      cmd_UART = 16'h0000;
    logic             cmd_rdy_UART = 1'b0;
    logic [15:0]      cmd;
    logic             cmd_rdy;
    logic             clr_cmd_rdy = 1'b0;
    logic             send_resp = 1'b0;
    logic [7:0]       resp;
    logic             tour_busy;
    logic             tour_done;
    logic             move_err;

    logic [7:0]  tl_moves [32];
    logic [15:0] exp_q [$];
    int          checks   = 0;
    int          errors   = 0;
    int          done_cnt = 0;
    int          err_cnt  = 0;

    always #5 clk = ~clk;

    assign move = tl_moves[mv_indx];

    tour_cmd_seq dut (
        .clk          (clk),
        .rst          (rst),
        .start_tour   (start_tour),
        .vert_first   (vert_first),
        .abort        (abort),
        .move         (move),
        .mv_indx      (mv_indx),
        .cmd_UART     (cmd_UART),
        .cmd_rdy_UART (cmd_rdy_UART),
        .cmd          (cmd),
        .cmd_rdy      (cmd_rdy),
        .clr_cmd_rdy  (clr_cmd_rdy),
        .send_resp    (send_resp),
        .resp         (resp),
        .tour_busy    (tour_busy),
        .tour_done    (tour_done),
        .move_err     (move_err)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: knight displacement (dx,dy) for each one-hot bit, turned into a single-axis command
    function automatic logic [15:0] leg_cmd(input logic [7:0] m, input bit vertical);
        int dx;
        int dy;
        int mag;
        logic [7:0] hdg;
        dx = 0;
        dy = 0;
        for (int b = 0; b < 8; b++) begin
            if (m[b]) begin
                case (b)
                    0: begin dx = -1; dy =  2; end
                    1: begin dx =  1; dy =  2; end
                    2: begin dx = -2; dy =  1; end
                    3: begin dx = -2; dy = -1; end
                    4: begin dx = -1; dy = -2; end
                    5: begin dx =  1; dy = -2; end
                    6: begin dx =  2; dy = -1; end
                    default: begin dx = 2; dy = 1; end
                endcase
            end
        end
        if (vertical) begin
            hdg = (dy > 0) ? 8'h00 : 8'h7F;
            mag = (dy < 0) ? -dy : dy;
            return {4'h2, hdg, mag[3:0]};
        end
        hdg = (dx > 0) ? 8'hBF : 8'h3F;
        mag = (dx < 0) ? -dx : dx;
        return {4'h3, hdg, mag[3:0]};
    endfunction

    always @(negedge clk) begin
        if (tour_done) done_cnt++;
        if (move_err)  err_cnt++;
        if (cmd_rdy && clr_cmd_rdy && !rst) begin
            if (exp_q.size() == 0) checkOutput("queue_underflow", exp_q.size(), 1);
            else                   checkOutput("cmd", cmd, exp_q.pop_front());
        end
    end

    task automatic waitRdy(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (cmd_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput("cmd_rdy_timeout", cmd_rdy, 1);
    endtask

    task automatic clrPulse();
        @(posedge clk); #1 clr_cmd_rdy = 1'b1;
        @(posedge clk); #1 clr_cmd_rdy = 1'b0;
    endtask

    task automatic sendPulse();
        @(posedge clk); #1 send_resp = 1'b1;
        @(posedge clk); #1 send_resp = 1'b0;
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        rst = 1'b1; abort = 1'b0; start_tour = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_busy", tour_busy, 0);
        checkOutput("rst_idx", mv_indx, 0);
        checkOutput("rst_done", tour_done, 0);
        checkOutput("rst_err", move_err, 0);
        checkOutput("rst_resp", resp, 8'hA5);
        checkOutput("rst_rdy", cmd_rdy, cmd_rdy_UART);
    endtask

    // stop_kind: 0 full tour, 1 bad move at stop_idx, 2 abort in WAIT1, 3 reset in LEG2
    task automatic applyStimulus(input bit vert, input bit fixed01, input int stop_idx, input int stop_kind);
        int d0;
        int e0;
        bit ok;
        bit seen_rdy;
        logic [15:0] l1;
        logic [15:0] l2;
        d0 = done_cnt;
        e0 = err_cnt;
        for (int i = 0; i < NUM_MOVES; i++)
            tl_moves[i] = fixed01 ? 8'h01 : (8'h01 << $urandom_range(0, 7));
        if (stop_kind == 1) tl_moves[stop_idx] = 8'h03;
        for (int i = 0; i < NUM_MOVES; i++) begin
            if (stop_kind != 0 && i > stop_idx) break;
            if (stop_kind == 1 && i == stop_idx) break;
            exp_q.push_back(leg_cmd(tl_moves[i], vert));
            if (!(stop_kind >= 2 && i == stop_idx)) exp_q.push_back(leg_cmd(tl_moves[i], !vert));
        end
        cmd_rdy_UART = (stop_kind == 0);
        cmd_UART = 16'($urandom);
        @(posedge clk); #1 start_tour = 1'b1; vert_first = vert;
        @(posedge clk); #1 start_tour = 1'b0; vert_first = 1'($urandom);
        for (int i = 0; i < NUM_MOVES; i++) begin
            if (stop_kind == 1 && i == stop_idx) break;
            l1 = leg_cmd(tl_moves[i], vert);
            l2 = leg_cmd(tl_moves[i], !vert);
            waitRdy(ok);
            if (!ok) return;
            checkOutput("leg1_idx", mv_indx, i);
            checkOutput("leg1_resp", resp, 8'h5A);
            checkOutput("leg1_busy", tour_busy, 1);
            if (i == 3) begin
                @(posedge clk); #1 start_tour = 1'b1;
                @(posedge clk); #1 start_tour = 1'b0;
                @(negedge clk);
                checkOutput("start_ignored_idx", mv_indx, 3);
                checkOutput("start_ignored_rdy", cmd_rdy, 1);
            end
            clrPulse();
            @(negedge clk);
            checkOutput("wait1_rdy", cmd_rdy, 0);
            checkOutput("wait1_cmd", cmd, l1);
            if (stop_kind == 2 && i == stop_idx) begin
                @(posedge clk); #1 abort = 1'b1; send_resp = 1'b1;
                @(posedge clk); #1 abort = 1'b0; send_resp = 1'b0;
                @(negedge clk);
                checkOutput("abort_busy", tour_busy, 0);
                checkOutput("abort_cmd", cmd, cmd_UART);
                checkOutput("abort_idx", mv_indx, i);
                repeat (3) @(negedge clk);
                checkOutput("abort_no_leg2", cmd_rdy, 0);
                break;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            sendPulse();
            waitRdy(ok);
            if (!ok) return;
            checkOutput("leg2_idx", mv_indx, i);
            if (stop_kind == 3 && i == stop_idx) begin
                @(posedge clk); #1 rst = 1'b1;
                @(posedge clk); #1 rst = 1'b0;
                @(negedge clk);
                checkOutput("midrst_busy", tour_busy, 0);
                checkOutput("midrst_idx", mv_indx, 0);
                checkOutput("midrst_rdy", cmd_rdy, 0);
                break;
            end
            clrPulse();
            @(negedge clk);
            checkOutput("wait2_rdy", cmd_rdy, 0);
            checkOutput("wait2_cmd", cmd, l2);
            checkOutput("wait2_resp", resp, (i == NUM_MOVES - 1) ? 8'hA5 : 8'h5A);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            sendPulse();
        end
        seen_rdy = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (stop_kind == 1 && cmd_rdy) seen_rdy = 1'b1;
        end
        checkOutput("end_busy", tour_busy, 0);
        checkOutput("done_pulses", done_cnt - d0, (stop_kind == 0) ? 1 : 0);
        checkOutput("err_pulses", err_cnt - e0, (stop_kind == 1) ? 1 : 0);
        if (stop_kind == 0) begin
            checkOutput("end_idx", mv_indx, NUM_MOVES - 1);
            checkOutput("end_resp", resp, 8'hA5);
        end
        if (stop_kind == 1) begin
            checkOutput("err_idx", mv_indx, stop_idx);
            checkOutput("err_no_rdy", seen_rdy, 0);
        end
        checkOutput("queue_empty", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) tl_moves[i] = 8'h00;
        doReset();
        cmd_UART = 16'h2001;
        cmd_rdy_UART = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("uart_cmd", cmd, cmd_UART);
            checkOutput("uart_rdy", cmd_rdy, cmd_rdy_UART);
            checkOutput("uart_resp", resp, 8'hA5);
            checkOutput("uart_busy", tour_busy, 0);
            @(posedge clk); #1;
            cmd_UART = 16'($urandom);
            cmd_rdy_UART = 1'($urandom);
        end
        $display("[TB] full tour, move 8'h01, vertical first");
        applyStimulus(1'b1, 1'b1, 0, 0);
        for (int t = 0; t < 3; t++) begin
            $display("[TB] random tour %0d", t);
            applyStimulus(1'(t & 1), 1'b0, 0, 0);
        end
        doReset();
        $display("[TB] bad move at index 5");
        applyStimulus(1'($urandom), 1'b0, 5, 1);
        doReset();
        $display("[TB] abort in WAIT1");
        applyStimulus(1'($urandom), 1'b0, $urandom_range(0, NUM_MOVES - 1), 2);
        doReset();
        $display("[TB] reset in LEG2");
        applyStimulus(1'($urandom), 1'b0, $urandom_range(1, NUM_MOVES - 1), 3);
        doReset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
